// File: rtl/vit_pkg.sv
// Shared Viterbi trellis constants, FSM state encoding and the predecessor-state
// rule used by both the ACS/survivor writer and the traceback unit.
package vit_pkg;

  localparam int ST_W   = 2;
  localparam int STEP_W = 8;
  localparam int ADDR_W = STEP_W + ST_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    USE  = 2'd2,
    FIN  = 2'd3
  } state_e;

  // Shift-register trellis: the older state is the current state shifted up
  // with the survivor decision entering at the LSB.
  function automatic logic [ST_W-1:0] pred_state(input logic [ST_W-1:0] cur,
                                                 input logic            decision);
    return {cur[ST_W-2:0], decision};
  endfunction

endpackage

// File: rtl/vit_traceback.sv
// Viterbi survivor-memory traceback: walks the trellis backwards from a given
// state/step, emitting one decoded bit per read (newest step first).
module vit_traceback
  import vit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ST_W-1:0]   start_state,
  input  logic [STEP_W-1:0] end_step,
  input  logic [STEP_W-1:0] length,
  input  logic              mem_hold,
  input  logic              mem_d,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              dout_valid,
  output logic              dout,
  output logic              done
);

  state_e              state_q, state_d;
  logic [ST_W-1:0]     cur_state_q, cur_state_d;
  logic [STEP_W-1:0]   cur_step_q, cur_step_d;
  logic [STEP_W:0]     remaining_q, remaining_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    cur_state_d = cur_state_q;
    cur_step_d  = cur_step_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RD;
          cur_state_d = start_state;
          cur_step_d  = end_step;
          remaining_d = (length == '0) ? (STEP_W+1)'(256) : {1'b0, length};
        end
      end
      RD: begin
        addr_d = {cur_step_q, cur_state_q};
        if (!mem_hold) state_d = USE;
      end
      USE: begin
        cur_state_d = pred_state(cur_state_q, mem_d);
        cur_step_d  = cur_step_q - 1'b1;
        remaining_d = remaining_q - 1'b1;
        state_d     = (remaining_q > (STEP_W+1)'(1)) ? RD : FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_state_q <= '0;
      cur_step_q  <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      cur_state_q <= cur_state_d;
      cur_step_q  <= cur_step_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
    end
  end

  // Address is live during RD and frozen elsewhere, so memory sees it in the RD cycle itself.
  assign mem_addr   = (state_q == RD) ? {cur_step_q, cur_state_q} : addr_q;
  assign busy       = (state_q == RD) || (state_q == USE);
  assign dout_valid = (state_q == USE);
  assign dout       = (state_q == USE) ? cur_state_q[ST_W-1] : 1'b0;
  assign done       = (state_q == FIN);

endmodule

// File: tb/tb_vit_traceback.sv
// Self-checking bench for vit_traceback: 1-cycle registered survivor memory model
// plus a step-by-step trellis walk used as the reference.
module tb_vit_traceback;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] start_state = '0;
  logic [7:0] end_step = '0;
  logic [7:0] length = '0;
  logic       mem_hold = 1'b0;
  logic       mem_d;
  logic [9:0] mem_addr;
  logic       busy, dout_valid, dout, done;

  logic mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  int last_bits[$];
  int last_addr[$];
  int last_done_cyc;
  int last_max_rep;

  always #5 clk = ~clk;

  // Registered read; while the port is being written the read data is junk.
  always @(posedge clk) mem_d <= mem_hold ? 1'($urandom) : mem[mem_addr];

  vit_traceback dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_state(start_state),
    .end_step   (end_step),
    .length     (length),
    .mem_hold   (mem_hold),
    .mem_d      (mem_d),
    .mem_addr   (mem_addr),
    .busy       (busy),
    .dout_valid (dout_valid),
    .dout       (dout),
    .done       (done)
  );

  task automatic fill_mem_random();
    for (int i = 0; i < 1024; i++) mem[i] = 1'($urandom);
  endtask

  // mode bit0: extra start at cycle 3 (mid-run); bit1: extra start in the done cycle.
  task automatic run(input string name, input int ss, input int es, input int ln,
                     input int hold_at, input int hold_n, input int mode);
    int n, exp_done, s, stp, d;
    int exp_bits[$], exp_addr[$], got_bits[$], got_addr[$];
    int first_valid, done_cyc, done_cnt, busy_cnt, rd_cnt, rep, max_rep;
    n = (ln == 0) ? 256 : ln;
    exp_done = 2 * n + 1 + hold_n;
    s = ss; stp = es;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(stp * 4 + s);
      exp_bits.push_back(s / 2);
      d = int'(mem[stp * 4 + s]);
      s = (s * 2 + d) % 4;
      stp = (stp + 255) % 256;
    end
    first_valid = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0; rd_cnt = 0;
    rep = 0; max_rep = 0;

    for (int c = 0; c <= exp_done + 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        start = 1'b1; start_state = 2'(ss); end_step = 8'(es); length = 8'(ln);
      end else begin
        start = ((mode & 1) != 0 && c == 3) || ((mode & 2) != 0 && c == exp_done);
        start_state = 2'($urandom); end_step = 8'($urandom); length = 8'($urandom);
      end
      mem_hold = (c >= hold_at) && (c < hold_at + hold_n);
      @(negedge clk);
      if (dout_valid) begin
        got_bits.push_back(int'(dout));
        if (first_valid < 0) first_valid = c;
        rep = 0;
      end else if (busy) begin
        rd_cnt++;
        if (got_addr.size() == 0 || got_addr[$] != int'(mem_addr)) begin
          got_addr.push_back(int'(mem_addr));
          rep = 1;
        end else rep++;
        if (rep > max_rep) max_rep = rep;
      end
      if (done) begin done_cnt++; done_cyc = c; end
      if (busy) busy_cnt++;
    end
    start = 1'b0; mem_hold = 1'b0;

    n_checks++;
    if (got_bits.size() != n) begin
      n_errors++; $display("FAIL %s bit_count: got %0d want %0d", name, got_bits.size(), n);
    end
    for (int i = 0; i < n && i < got_bits.size(); i++) begin
      n_checks++;
      if (got_bits[i] != exp_bits[i]) begin
        n_errors++; $display("FAIL %s bit[%0d]: got %0d want %0d", name, i, got_bits[i], exp_bits[i]);
      end
    end
    n_checks++;
    if (got_addr.size() != n) begin
      n_errors++; $display("FAIL %s addr_count: got %0d want %0d", name, got_addr.size(), n);
    end
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      n_checks++;
      if (got_addr[i] != exp_addr[i]) begin
        n_errors++; $display("FAIL %s addr[%0d]: got %0d want %0d", name, i, got_addr[i], exp_addr[i]);
      end
    end
    n_checks++;
    if (first_valid != 2) begin
      n_errors++; $display("FAIL %s latency: got %0d want 2", name, first_valid);
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc != exp_done) begin
      n_errors++; $display("FAIL %s done: got %0d pulses at %0d want 1 at %0d", name, done_cnt, done_cyc, exp_done);
    end
    n_checks++;
    if (busy_cnt != exp_done - 1) begin
      n_errors++; $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, exp_done - 1);
    end
    n_checks++;
    if (rd_cnt != n + hold_n) begin
      n_errors++; $display("FAIL %s rd_cycles: got %0d want %0d", name, rd_cnt, n + hold_n);
    end
    last_bits = got_bits; last_addr = got_addr;
    last_done_cyc = done_cyc; last_max_rep = max_rep;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({busy, dout_valid, dout, done, mem_addr} !== 14'd0) begin
      n_errors++; $display("FAIL reset_outputs: got %b want 0", {busy, dout_valid, dout, done, mem_addr});
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_errors++; $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    int want_bits[3] = '{1, 0, 1};
    int want_addr[3] = '{22, 17, 15};
    fill_mem_random();
    mem[22] = 1'b1; mem[17] = 1'b1; mem[15] = 1'b0;
    run("directed", 2, 5, 3, -1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (last_bits.size() != 3 || last_bits[i] != want_bits[i] || last_addr.size() != 3
          || last_addr[i] != want_addr[i]) begin
        n_errors++; $display("FAIL directed_seq[%0d]: got bits=%p addr=%p want bit %0d addr %0d",
                             i, last_bits, last_addr, want_bits[i], want_addr[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int want_steps[4] = '{1, 0, 255, 254};
    fill_mem_random();
    run("wrap", int'($urandom_range(3)), 1, 4, -1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (last_addr.size() != 4 || last_addr[i] / 4 != want_steps[i]) begin
        n_errors++; $display("FAIL wrap_step[%0d]: got addr=%p want step %0d", i, last_addr, want_steps[i]);
      end
    end
  endtask

  task automatic test_hold();
    int ref_bits[$];
    int ref_done, ss, es;
    fill_mem_random();
    ss = int'($urandom_range(3)); es = int'($urandom_range(255));
    run("nohold", ss, es, 6, -1, 0, 0);
    ref_bits = last_bits; ref_done = last_done_cyc;
    run("hold", ss, es, 6, 3, 3, 0);
    n_checks++;
    if (last_bits != ref_bits) begin
      n_errors++; $display("FAIL hold_bits: got %p want %p", last_bits, ref_bits);
    end
    n_checks++;
    if (last_done_cyc != ref_done + 3) begin
      n_errors++; $display("FAIL hold_done: got %0d want %0d", last_done_cyc, ref_done + 3);
    end
    n_checks++;
    if (last_max_rep != 4) begin
      n_errors++; $display("FAIL hold_addr_repeat: got %0d want 4", last_max_rep);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      fill_mem_random();
      run("random", int'($urandom_range(3)), int'($urandom_range(255)),
          int'($urandom_range(20, 1)), -1, 0, 0);
    end
  endtask

  task automatic test_len_zero();
    fill_mem_random();
    run("len_zero", int'($urandom_range(3)), int'($urandom_range(255)), 0, -1, 0, 0);
  endtask

  task automatic test_start_ignored();
    fill_mem_random();
    run("start_ignored", int'($urandom_range(3)), int'($urandom_range(255)), 5, -1, 0, 3);
  endtask

  task automatic test_reset_mid_run();
    int done_seen = 0;
    fill_mem_random();
    @(posedge clk); #1;
    start = 1'b1; start_state = 2'd3; end_step = 8'd40; length = 8'd10;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, dout_valid, dout, done, mem_addr} !== 14'd0) begin
      n_errors++; $display("FAIL async_reset_outputs: got %b want 0", {busy, dout_valid, dout, done, mem_addr});
    end
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_errors++; $display("FAIL reset_no_done: got %0d active cycles want 0", done_seen);
    end
    run("after_reset", int'($urandom_range(3)), int'($urandom_range(255)), 7, -1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wrap();
    test_hold();
    test_random();
    test_len_zero();
    test_start_ignored();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vit_traceback.md
VIT_TRACEBACK -- requirements
Module: vit_traceback

Interface
REQ-001 Parameters: none; all widths come from the shared package constants (ST_W=2, STEP_W=8, ADDR_W=10).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a traceback; honoured only in IDLE.
REQ-005 start_state  input  2  trellis state at the newest step, sampled with start.
REQ-006 end_step  input  8  newest trellis step index, sampled with start.
REQ-007 length  input  8  number of steps to trace; 0 means 256; sampled with start.
REQ-008 mem_hold  input  1  survivor memory port is being written this cycle; the read result is invalid.
REQ-009 mem_d  input  1  survivor decision bit, valid one cycle after mem_addr was driven with mem_hold low.
REQ-010 mem_addr  output  10  survivor memory read address = {step[7:0], state[1:0]}.
REQ-011 busy  output  1  high from the cycle after an accepted start until done is asserted.
REQ-012 dout_valid  output  1  one-cycle strobe marking a decoded bit.
REQ-013 dout  output  1  decoded bit; meaningful only when dout_valid is high.
REQ-014 done  output  1  one-cycle pulse after the last decoded bit.

Function
REQ-015 FSM states: IDLE, RD, USE, FIN.
  - IDLE->RD on start.
  - RD->USE when mem_hold is low; RD holds while mem_hold is high.
  - USE->RD while the remaining count is >1.
  - USE->FIN when the remaining count is 1.
  - FIN->IDLE unconditionally.
REQ-016 On an accepted start, latch: cur_state=start_state, cur_step=end_step, remaining=length (0 loads 256, 9-bit counter).
REQ-017 In RD, mem_addr = {cur_step, cur_state}; in every other state mem_addr holds its last value.
REQ-018 In USE, for cur_state=(s1,s0) with decision d=mem_d:
  - dout=s1 with dout_valid=1.
  - next cur_state=(s0,d).
  - cur_step decrements modulo 256 (0 wraps to 255).
  - remaining decrements.
REQ-019 If mem_hold is high during a RD cycle, the following cycle is RD again with the same address; no bit is emitted.
REQ-020 Throughput: one decoded bit per 2 cycles with no hold; latency from start to first dout_valid = 2 cycles.
REQ-021 Decoded bits are emitted newest step first (reverse time order); reordering is outside this block.
REQ-022 done is high for exactly the FIN cycle; busy drops in the same cycle done rises.
REQ-023 A start asserted while not in IDLE is ignored with no side effects; a start coincident with FIN is also ignored.
REQ-024 The block never writes the memory; write/read arbitration is signalled only through mem_hold.

Reset
REQ-025 rst forces the FSM to IDLE with busy=0, dout_valid=0, dout=0, done=0, mem_addr=0, cur_state=0, cur_step=0, remaining=0, regardless of clk.
REQ-026 Reset mid-traceback abandons the operation; no done pulse is generated; the first start after reset release is accepted normally.

Structure
REQ-027 Package vit_pkg holds ST_W, STEP_W, ADDR_W, the FSM state enum, and the predecessor-state function, shared with the ACS/survivor writer.
REQ-028 The block is a single module with no sub-modules; the predecessor computation is a package function, not a separate instance.

Verification
REQ-029 Memory model: 1024x1 array with a 1-cycle registered read, preloaded as follows:
  - start_state=2'b10, end_step=5, length=3, no hold.
  - Decisions at {5,10}=1, {4,01}=1, {3,11}=0.
  - Required: dout sequence 1,0,1 at cycles 2,4,6 after start; addresses {5,10},{4,01},{3,11}; done at cycle 7.
REQ-030 Wrap: end_step=1, length=4 -> addresses visit steps 1,0,255,254 in order.
REQ-031 Hold: mem_hold high for 3 cycles during the second RD -> same mem_addr for 4 cycles; dout values identical to the no-hold run; done 3 cycles later.
REQ-032 length=0 -> exactly 256 dout_valid strobes, then one done pulse; busy high for 512 cycles.
REQ-033 Start while busy, and start in the FIN cycle -> both ignored; latched parameters unchanged; the original run completes with correct data.
REQ-034 rst asserted asynchronously mid-run (between clock edges) -> outputs zero immediately; no done pulse; a new start after release produces a correct full run.
